mips_control_ifid_pc_sequencer: RTL and testbench
=================================================

MIPS_CONTROL_IFID_PC_SEQUENCER -- requirements
Module: Mips_Control_IfId_Pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set address/operand width; legal values are 32 and above.
REQ-002 Parameter RESET_VECTOR, default 32'hBFC00000, SHALL set the pc value after reset.
REQ-003 Parameter EXC_VECTOR, default 32'hBFC00380, SHALL set the pc value loaded on exception.
REQ-004 Parameter DELAY_SLOT, default 1, SHALL select the mode: 1 = architectural delay slot, no squash; 0 = squash the wrong-path fetch.
REQ-005 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-007 stall  input  1  SHALL hold the fetch address this cycle.
REQ-008 except  input  1  SHALL be the exception redirect request from a later stage.
REQ-009 valid  input  1  SHALL mark the decode-stage inputs as a real instruction.
REQ-010 action  input  2  SHALL be the decode action: 0 Inc, 1 Jump, 2 JumpR, 3 Branch.
REQ-011 condition  input  3  SHALL be the branch condition: 0 None, 1 EQ, 2 NE, 3 LT, 4 LE, 5 GT, 6 GE; 7 is treated as None.
REQ-012 decodePc  input  WIDTH  SHALL be the address of the instruction in decode.
REQ-013 rs, rt  input  WIDTH each  SHALL be the forwarded register operands.
REQ-014 offset  input  16  SHALL be the branch immediate.
REQ-015 index  input  26  SHALL be the jump index.
REQ-016 pc  output  WIDTH  SHALL be the registered fetch address.
REQ-017 flush  output  1  SHALL be a registered squash pulse for the IF/ID register.
REQ-018 addrError  output  1  SHALL be a registered misaligned-JumpR pulse.
REQ-019 link  output  WIDTH  SHALL be combinational and equal decodePc+8.
REQ-020 taken  output  1  SHALL be combinational and equal the resolved redirect decision of the current decode inputs.

Function
REQ-021 Target computation, all sums modulo 2^WIDTH:
- Branch: decodePc+4+(sign-extended offset<<2).
- Jump: {upper WIDTH-28 bits of decodePc+4, index, 2'b00}.
- JumpR: rs.
REQ-022 Conditions:
- EQ rs==rt; NE rs!=rt.
- LT, LE, GT, GE compare rs against zero as a signed value.
- None is false.
REQ-023 taken SHALL be valid AND one of: Jump; JumpR with rs[1:0]==0; Branch with true condition.
REQ-024 The block SHALL hold state RUN or PEND plus a WIDTH-bit pending-target register.
REQ-025 Each edge SHALL apply exactly one rule, in priority order except > stall > PEND > taken > increment.
REQ-026 except: pc<=EXC_VECTOR, state<=RUN, pending discarded, flush<=1, regardless of stall.
REQ-027 stall in RUN with taken: pc held, pending<=target, state<=PEND, flush<=0.
REQ-028 stall otherwise: pc, state and pending held, flush<=0; decode inputs ignored while in PEND.
REQ-029 !stall in PEND: pc<=pending, state<=RUN, flush<=!DELAY_SLOT; decode inputs ignored that cycle.
REQ-030 !stall in RUN with taken: pc<=target, flush<=!DELAY_SLOT.
REQ-031 Otherwise: pc<=pc+4 (wraps at 2^WIDTH), flush<=0.
REQ-032 valid with JumpR and rs[1:0]!=0: addrError<=1 for one cycle on the next unstalled or excepting edge; no redirect; pc follows REQ-031.
REQ-033 flush and addrError SHALL be single-cycle pulses unless the triggering condition recurs on consecutive edges.
REQ-034 valid=0 SHALL never redirect and never raise addrError.

Reset
REQ-035 While reset is high: pc=RESET_VECTOR, state=RUN, pending=0, flush=0, addrError=0, asynchronously.
REQ-036 The first edge after reset release SHALL follow REQ-025 normally; reset asserted mid-PEND SHALL discard the pending target.

Verification
REQ-037 Reset, no stimulus: pc=BFC00000; after 3 edges BFC0000C; flush=0.
REQ-038 Branch taken: decodePc=00400000, Branch EQ, rs=rt=5, offset=FFFF: taken=1, next pc=00400000, flush=0 (DELAY_SLOT=1) or flush=1 (DELAY_SLOT=0).
REQ-039 Stalled redirect: Jump, index=0000010, stall high 2 edges: pc held, state PEND. Then stall low with valid=0: pc=00000040.
REQ-040 Exception during PEND with stall=1: pc=BFC00380, flush=1, state RUN; pending target never appears on pc.
REQ-041 JumpR with rs=00400002: addrError pulses 1 cycle, pc=previous+4. Signed branches: rs=80000000 with LT taken, GE not taken; rs=0 with LE taken, GT not taken.
REQ-042 Wrap: pc=FFFFFFFC, increment: pc=00000000.

Source files
------------

// File: rtl/mips_control_ifid_pc_sequencer.sv
// Fetch-address sequencer for the IF/ID boundary: resolves decode-stage redirects,
// parks redirects that arrive while fetch is stalled, and handles exception entry.
module mips_control_ifid_pc_sequencer #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'hBFC00000),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'hBFC00380),
    parameter int unsigned      DELAY_SLOT   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             except,
    input  logic             valid,
    input  logic [1:0]       action,
    input  logic [2:0]       condition,
    input  logic [WIDTH-1:0] decodePc,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [15:0]      offset,
    input  logic [25:0]      index,
    output logic [WIDTH-1:0] pc,
    output logic             flush,
    output logic             addrError,
    output logic [WIDTH-1:0] link,
    output logic             taken
);

    localparam logic [1:0] ACT_INC    = 2'd0;
    localparam logic [1:0] ACT_JUMP   = 2'd1;
    localparam logic [1:0] ACT_JUMPR  = 2'd2;
    localparam logic [1:0] ACT_BRANCH = 2'd3;

    localparam logic [2:0] COND_EQ = 3'd1;
    localparam logic [2:0] COND_NE = 3'd2;
    localparam logic [2:0] COND_LT = 3'd3;
    localparam logic [2:0] COND_LE = 3'd4;
    localparam logic [2:0] COND_GT = 3'd5;
    localparam logic [2:0] COND_GE = 3'd6;

    // Without an architectural delay slot the instruction fetched behind a redirect is squashed.
    localparam logic SQUASH = 1'(DELAY_SLOT == 0);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] pc_d;
    logic             flush_d;
    logic             addr_err_d;

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] dec_pc4;
    logic [WIDTH-1:0] br_offset;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] j_target;
    logic [WIDTH-1:0] target;
    logic             rs_zero;
    logic             rs_neg;
    logic             cond_true;
    logic             misalign;

    assign pc_inc    = pc + WIDTH'(4);
    assign dec_pc4   = decodePc + WIDTH'(4);
    assign link      = decodePc + WIDTH'(8);
    assign br_offset = {{(WIDTH-18){offset[15]}}, offset, 2'b00};
    assign br_target = dec_pc4 + br_offset;
    assign j_target  = {dec_pc4[WIDTH-1:28], index, 2'b00};
    assign rs_zero   = (rs == '0);
    assign rs_neg    = rs[WIDTH-1];

    // Branch condition; the ordered compares are rs against zero, signed.
    always_comb begin
        cond_true = 1'b0;
        case (condition)
            COND_EQ: cond_true = (rs == rt);
            COND_NE: cond_true = (rs != rt);
            COND_LT: cond_true = rs_neg;
            COND_LE: cond_true = rs_neg || rs_zero;
            COND_GT: cond_true = !rs_neg && !rs_zero;
            COND_GE: cond_true = !rs_neg;
            default: cond_true = 1'b0;
        endcase
    end

    // Redirect decision and target for the instruction currently in decode.
    always_comb begin
        taken    = 1'b0;
        target   = dec_pc4;
        misalign = 1'b0;
        case (action)
            ACT_INC: begin
                taken  = 1'b0;
                target = dec_pc4;
            end
            ACT_JUMP: begin
                taken  = valid;
                target = j_target;
            end
            ACT_JUMPR: begin
                taken    = valid && (rs[1:0] == 2'b00);
                misalign = valid && (rs[1:0] != 2'b00);
                target   = rs;
            end
            ACT_BRANCH: begin
                taken  = valid && cond_true;
                target = br_target;
            end
            default: begin
                taken  = 1'b0;
                target = dec_pc4;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            pend_q    <= '0;
            pc        <= RESET_VECTOR;
            flush     <= 1'b0;
            addrError <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            pc        <= pc_d;
            flush     <= flush_d;
            addrError <= addr_err_d;
        end
    end

    // One rule per edge: except > stall > pending redirect > taken > increment.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pc_d       = pc_inc;
        flush_d    = 1'b0;
        addr_err_d = 1'b0;
        if (except) begin
            state_d    = RUN;
            pend_d     = '0;
            pc_d       = EXC_VECTOR;
            flush_d    = 1'b1;
            addr_err_d = misalign && (state_q == RUN);
        end else if (stall) begin
            pc_d = pc;
            if ((state_q == RUN) && taken) begin
                pend_d  = target;
                state_d = PEND;
            end
        end else if (state_q == PEND) begin
            pc_d    = pend_q;
            state_d = RUN;
            flush_d = SQUASH;
        end else if (taken) begin
            pc_d    = target;
            flush_d = SQUASH;
        end else begin
            addr_err_d = misalign;
        end
    end

endmodule

// File: tb/tb_mips_control_ifid_pc_sequencer.sv
// Bench for mips_control_ifid_pc_sequencer: both delay-slot modes driven in parallel
// and compared against a behavioural model of the redirect rules.
module tb_mips_control_ifid_pc_sequencer;

    localparam logic [31:0] RV = 32'hBFC00000;
    localparam logic [31:0] EV = 32'hBFC00380;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall, except, valid;
    logic [1:0]  action;
    logic [2:0]  condition;
    logic [31:0] decodePc, rs, rt;
    logic [15:0] offset;
    logic [25:0] index;

    logic [31:0] pc1, pc0, link1, link0;
    logic        flush1, flush0, ae1, ae0, taken1, taken0;

    int errors = 0;
    int checks = 0;

    // Model state
    logic [31:0] m_pc, m_tgt;
    bit          m_pend, m_f1, m_f0, m_ae;

    always #5 clock = ~clock;

    mips_control_ifid_pc_sequencer #(.DELAY_SLOT(1)) dut1 (
        .clock(clock), .reset(reset), .stall(stall), .except(except), .valid(valid),
        .action(action), .condition(condition), .decodePc(decodePc), .rs(rs), .rt(rt),
        .offset(offset), .index(index), .pc(pc1), .flush(flush1), .addrError(ae1),
        .link(link1), .taken(taken1));

    mips_control_ifid_pc_sequencer #(.DELAY_SLOT(0)) dut0 (
        .clock(clock), .reset(reset), .stall(stall), .except(except), .valid(valid),
        .action(action), .condition(condition), .decodePc(decodePc), .rs(rs), .rt(rt),
        .offset(offset), .index(index), .pc(pc0), .flush(flush0), .addrError(ae0),
        .link(link0), .taken(taken0));

    function automatic bit ref_cond();
        int signed s;
        s = $signed(rs);
        case (condition)
            3'd1: return rs == rt;
            3'd2: return rs != rt;
            3'd3: return s < 0;
            3'd4: return s <= 0;
            3'd5: return s > 0;
            3'd6: return s >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit ref_taken();
        if (!valid) return 1'b0;
        case (action)
            2'd1: return 1'b1;
            2'd2: return rs % 4 == 0;
            2'd3: return ref_cond();
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_target();
        logic [31:0] pc4;
        int signed   off;
        pc4 = decodePc + 32'd4;
        off = int'($signed(offset));
        case (action)
            2'd1: return {pc4[31:28], index, 2'b00};
            2'd2: return rs;
            default: return pc4 + 32'(off * 4);
        endcase
    endfunction

    task automatic model_reset();
        m_pc = RV; m_tgt = '0; m_pend = 0; m_f1 = 0; m_f0 = 0; m_ae = 0;
    endtask

    task automatic idle_inputs();
        stall = 0; except = 0; valid = 0; action = 2'd0; condition = 3'd0;
        decodePc = 32'h00400000; rs = '0; rt = '0; offset = '0; index = '0;
    endtask

    // Advance the model on the current inputs, then clock the DUTs.
    task automatic drive_edge();
        logic [31:0] npc, ntgt;
        bit npend, nf1, nf0, nae, t, mis;
        t    = ref_taken();
        mis  = valid && action == 2'd2 && rs % 4 != 0;
        npc  = m_pc + 32'd4; ntgt = m_tgt; npend = m_pend;
        nf1 = 0; nf0 = 0; nae = 0;
        if (except) begin
            npc = EV; npend = 0; nf1 = 1; nf0 = 1; nae = mis && !m_pend;
        end else if (stall) begin
            npc = m_pc;
            if (!m_pend && t) begin npend = 1; ntgt = ref_target(); end
        end else if (m_pend) begin
            npc = m_tgt; npend = 0; nf0 = 1;
        end else if (t) begin
            npc = ref_target(); nf0 = 1;
        end else begin
            nae = mis;
        end
        @(posedge clock);
        #1;
        m_pc = npc; m_tgt = ntgt; m_pend = npend; m_f1 = nf1; m_f0 = nf0; m_ae = nae;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        checks++;
        if (pc1 !== RV || pc0 !== RV) begin
            errors++; $display("FAIL reset_pc: got %h/%h expected %h", pc1, pc0, RV);
        end
        checks++;
        if ({flush1, flush0, ae1, ae0} !== 4'b0000) begin
            errors++; $display("FAIL reset_pulses: got %b expected 0000", {flush1, flush0, ae1, ae0});
        end
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (pc1 !== RV) begin
            errors++; $display("FAIL reset_held_pc: got %h expected %h", pc1, RV);
        end
        reset = 1'b0;
    endtask

    task automatic test_increment();
        repeat (3) drive_edge();
        checks++;
        if (pc1 !== 32'hBFC0000C || pc0 !== 32'hBFC0000C || m_pc !== 32'hBFC0000C) begin
            errors++; $display("FAIL increment_pc: got %h/%h expected %h", pc1, pc0, 32'hBFC0000C);
        end
        checks++;
        if (flush1 !== 1'b0 || flush0 !== 1'b0) begin
            errors++; $display("FAIL increment_flush: got %b/%b expected 0", flush1, flush0);
        end
    endtask

    task automatic test_branch();
        valid = 1; action = 2'd3; condition = 3'd1;
        decodePc = 32'h00400000; rs = 32'd5; rt = 32'd5; offset = 16'hFFFF;
        #1;
        checks++;
        if (taken1 !== 1'b1 || taken0 !== 1'b1) begin
            errors++; $display("FAIL branch_taken: got %b/%b expected 1", taken1, taken0);
        end
        checks++;
        if (link1 !== 32'h00400008) begin
            errors++; $display("FAIL branch_link: got %h expected %h", link1, 32'h00400008);
        end
        drive_edge();
        idle_inputs();
        checks++;
        if (pc1 !== 32'h00400000 || pc0 !== 32'h00400000) begin
            errors++; $display("FAIL branch_pc: got %h/%h expected %h", pc1, pc0, 32'h00400000);
        end
        checks++;
        if (flush1 !== 1'b0 || flush0 !== 1'b1) begin
            errors++; $display("FAIL branch_flush: got ds1=%b ds0=%b expected ds1=0 ds0=1", flush1, flush0);
        end
        drive_edge();
        checks++;
        if (flush0 !== 1'b0 || pc1 !== 32'h00400004) begin
            errors++; $display("FAIL branch_after: got flush=%b pc=%h expected 0 %h", flush0, pc1, 32'h00400004);
        end
    endtask

    task automatic test_stall_redirect();
        logic [31:0] held;
        held = m_pc;
        valid = 1; action = 2'd1; index = 26'h0000010; decodePc = 32'h00400000; stall = 1;
        repeat (2) drive_edge();
        checks++;
        if (pc1 !== held || pc0 !== held) begin
            errors++; $display("FAIL stall_hold_pc: got %h/%h expected %h", pc1, pc0, held);
        end
        idle_inputs();
        drive_edge();
        checks++;
        if (pc1 !== 32'h00000040 || pc0 !== 32'h00000040) begin
            errors++; $display("FAIL stall_pend_pc: got %h/%h expected %h", pc1, pc0, 32'h00000040);
        end
        checks++;
        if (flush1 !== 1'b0 || flush0 !== 1'b1) begin
            errors++; $display("FAIL stall_pend_flush: got ds1=%b ds0=%b expected ds1=0 ds0=1", flush1, flush0);
        end
    endtask

    task automatic test_exception_pend();
        valid = 1; action = 2'd1; index = 26'h0000100; stall = 1;
        drive_edge();
        except = 1;
        drive_edge();
        checks++;
        if (pc1 !== EV || pc0 !== EV || flush1 !== 1'b1 || flush0 !== 1'b1) begin
            errors++; $display("FAIL exc_pend: got pc=%h/%h flush=%b/%b expected %h 1/1", pc1, pc0, flush1, flush0, EV);
        end
        idle_inputs();
        drive_edge();
        checks++;
        if (pc1 !== EV + 32'd4 || pc0 !== EV + 32'd4 || flush0 !== 1'b0) begin
            errors++; $display("FAIL exc_discard: got pc=%h flush0=%b expected %h 0", pc1, flush0, EV + 32'd4);
        end
    endtask

    task automatic test_addr_error_and_signed();
        logic [31:0] prev;
        prev = m_pc;
        valid = 1; action = 2'd2; rs = 32'h00400002;
        #1;
        checks++;
        if (taken1 !== 1'b0) begin
            errors++; $display("FAIL jr_misalign_taken: got %b expected 0", taken1);
        end
        drive_edge();
        idle_inputs();
        checks++;
        if (ae1 !== 1'b1 || ae0 !== 1'b1 || pc1 !== prev + 32'd4) begin
            errors++; $display("FAIL jr_addr_error: got ae=%b/%b pc=%h expected 1/1 %h", ae1, ae0, pc1, prev + 32'd4);
        end
        drive_edge();
        checks++;
        if (ae1 !== 1'b0 || ae0 !== 1'b0) begin
            errors++; $display("FAIL jr_pulse_end: got %b/%b expected 0", ae1, ae0);
        end
        valid = 1; action = 2'd3; rs = 32'h80000000;
        for (int i = 0; i < 4; i++) begin
            bit exp;
            case (i)
                0: begin rs = 32'h80000000; condition = 3'd3; exp = 1; end
                1: begin rs = 32'h80000000; condition = 3'd6; exp = 0; end
                2: begin rs = 32'h00000000; condition = 3'd4; exp = 1; end
                default: begin rs = 32'h00000000; condition = 3'd5; exp = 0; end
            endcase
            #1;
            checks++;
            if (taken1 !== exp || taken0 !== exp) begin
                errors++; $display("FAIL signed_cond%0d: got %b expected %b", i, taken1, exp);
            end
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        valid = 1; action = 2'd2; rs = 32'hFFFFFFFC;
        drive_edge();
        idle_inputs();
        checks++;
        if (pc1 !== 32'hFFFFFFFC) begin
            errors++; $display("FAIL wrap_setup: got %h expected %h", pc1, 32'hFFFFFFFC);
        end
        drive_edge();
        checks++;
        if (pc1 !== 32'h00000000 || pc0 !== 32'h00000000) begin
            errors++; $display("FAIL wrap_pc: got %h/%h expected 00000000", pc1, pc0);
        end
    endtask

    task automatic test_reset_mid_pend();
        valid = 1; action = 2'd1; index = 26'h0000200; stall = 1;
        drive_edge();
        reset = 1;
        model_reset();
        #1;
        checks++;
        if (pc1 !== RV || pc0 !== RV) begin
            errors++; $display("FAIL reset_async: got %h/%h expected %h", pc1, pc0, RV);
        end
        @(posedge clock);
        #1;
        reset = 0;
        idle_inputs();
        drive_edge();
        checks++;
        if (pc1 !== RV + 32'd4 || flush0 !== 1'b0) begin
            errors++; $display("FAIL reset_discard: got pc=%h flush0=%b expected %h 0", pc1, flush0, RV + 32'd4);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bit exp_t;
            stall     = $urandom_range(0, 3) == 0;
            except    = $urandom_range(0, 19) == 0;
            valid     = $urandom_range(0, 9) < 7;
            action    = 2'($urandom);
            condition = 3'($urandom);
            decodePc  = 32'($urandom) & 32'hFFFFFFFC;
            case ($urandom_range(0, 3))
                0: rs = '0;
                1: rs = 32'h80000000 | 32'($urandom);
                2: rs = 32'($urandom) & 32'hFFFFFFFC;
                default: rs = 32'($urandom);
            endcase
            rt     = ($urandom_range(0, 1) == 1) ? rs : 32'($urandom);
            offset = 16'($urandom);
            index  = 26'($urandom);
            #1;
            exp_t = ref_taken();
            checks++;
            if (taken1 !== exp_t || taken0 !== exp_t) begin
                errors++; $display("FAIL rnd_taken[%0d]: got %b/%b expected %b", n, taken1, taken0, exp_t);
            end
            checks++;
            if (link1 !== decodePc + 32'd8 || link0 !== decodePc + 32'd8) begin
                errors++; $display("FAIL rnd_link[%0d]: got %h expected %h", n, link1, decodePc + 32'd8);
            end
            drive_edge();
            checks++;
            if (pc1 !== m_pc || pc0 !== m_pc) begin
                errors++; $display("FAIL rnd_pc[%0d]: got %h/%h expected %h", n, pc1, pc0, m_pc);
            end
            checks++;
            if (flush1 !== m_f1 || flush0 !== m_f0) begin
                errors++; $display("FAIL rnd_flush[%0d]: got %b/%b expected %b/%b", n, flush1, flush0, m_f1, m_f0);
            end
            checks++;
            if (ae1 !== m_ae || ae0 !== m_ae) begin
                errors++; $display("FAIL rnd_addr_error[%0d]: got %b/%b expected %b", n, ae1, ae0, m_ae);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_increment();
        test_branch();
        test_stall_redirect();
        test_exception_pend();
        test_addr_error_and_signed();
        test_wrap();
        test_reset_mid_pend();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
